// File: rtl/custom_axi_ip_bank.sv
// Register-to-IP processing bank: NUM_CH write channels serviced round-robin by one engine.
// Accept ack one cycle after strobe; a result is published PROC_LATENCY+2 cycles after an idle-engine accept.
`timescale 1ns/1ps
module custom_axi_ip_bank #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_CH         = 3,
  parameter int                    PROC_LATENCY   = 2,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET_BASE = 'h2468,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET_STEP = 'h1234
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      reg2ip_data,
  input  logic [NUM_CH-1:0]                 reg2ip_en_in,
  output logic [NUM_CH-1:0]                 reg2ip_en_out,
  input  logic [1:0]                        mode_i,
  output logic [NUM_CH*(DATA_WIDTH+1)-1:0]  ip2reg_data,
  output logic [NUM_CH-1:0]                 ip2reg_en,
  output logic                              busy_o
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LW = (PROC_LATENCY > 1) ? $clog2(PROC_LATENCY) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] in_reg  [NUM_CH];
  logic [DATA_WIDTH-1:0] out_reg [NUM_CH];
  logic [NUM_CH-1:0]     valid;
  logic [NUM_CH-1:0]     pending;
  logic [CW-1:0]         ch;
  logic [CW-1:0]         rr;
  logic [1:0]            mode_l;
  logic [LW-1:0]         cnt;

  logic [NUM_CH-1:0]     accept;
  logic [NUM_CH-1:0]     clr;
  logic                  done;
  logic                  found;
  logic [CW-1:0]         pick;
  logic [CW-1:0]         idx;
  logic [DATA_WIDTH-1:0] result;

  // Acceptance looks only at registered pending, so a channel finishing this edge still rejects.
  assign accept = reg2ip_en_in & ~pending;
  assign done   = (state == EXEC) && (cnt == '0);
  assign clr    = done ? (NUM_CH'(1) << ch) : '0;
  assign busy_o = (|pending) || (state != IDLE);

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(rr) + k) % NUM_CH);
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    case (mode_l)
      2'b01:   result = out_reg[ch] + in_reg[ch];
      2'b10:   result = ~in_reg[ch];
      default: result = in_reg[ch];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        in_reg[i]  <= '0;
        out_reg[i] <= OUT_RESET_BASE + DATA_WIDTH'(i) * OUT_RESET_STEP;
      end
      valid         <= '0;
      pending       <= '0;
      reg2ip_en_out <= '0;
      ip2reg_en     <= '0;
      state         <= IDLE;
      ch            <= '0;
      rr            <= CW'(NUM_CH - 1);
      mode_l        <= 2'b00;
      cnt           <= '0;
    end else begin
      reg2ip_en_out <= accept;
      ip2reg_en     <= '0;
      pending       <= (pending | accept) & ~clr;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) in_reg[i] <= reg2ip_data[(NUM_CH-i)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
      case (state)
        IDLE: begin
          if (found) begin
            ch     <= pick;
            mode_l <= mode_i;
            cnt    <= LW'(PROC_LATENCY - 1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            out_reg[ch] <= result;
            valid[ch]   <= 1'b1;
            rr          <= ch;
            ip2reg_en   <= NUM_CH'(1) << ch;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ip2reg_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ip2reg_data[(NUM_CH-i)*(DATA_WIDTH+1)-1 -: DATA_WIDTH+1] = {out_reg[i], valid[i]};
    end
  end

endmodule

// File: tb/tb_custom_axi_ip_bank.sv
// Bench for custom_axi_ip_bank: timestamp-based service model plus directed literal scenarios.
`timescale 1ns/1ps
module tb_custom_axi_ip_bank;
  localparam int DW = 32, N = 3, L = 2;
  localparam logic [DW-1:0] BASE = 32'h2468, STEP = 32'h1234;

  logic clk = 1'b0, rst = 1'b1;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0] en_in = '0;
  logic [N-1:0] en_out;
  logic [1:0] mode = 2'b00;
  logic [N*(DW+1)-1:0] ipd;
  logic [N-1:0] ipen;
  logic busy;

  custom_axi_ip_bank #(.DATA_WIDTH(DW), .NUM_CH(N), .PROC_LATENCY(L),
                       .OUT_RESET_BASE(BASE), .OUT_RESET_STEP(STEP)) dut (
    .clk_i(clk), .rst_i(rst), .reg2ip_data(data), .reg2ip_en_in(en_in),
    .reg2ip_en_out(en_out), .mode_i(mode), .ip2reg_data(ipd),
    .ip2reg_en(ipen), .busy_o(busy));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW:0] field(input int i);
    return ipd[(N-i)*(DW+1)-1 -: DW+1];
  endfunction

  task automatic set_data(input int i, input logic [DW-1:0] v);
    data[(N-i)*DW-1 -: DW] = v;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: each pick at the end of an idle cycle t publishes in cycle t+1+L.
  logic [DW-1:0] m_in [N];
  logic [DW-1:0] m_out[N];
  logic [N-1:0]  m_valid, m_pend, m_ack, m_pub, acc;
  bit            m_act, start;
  int            m_ch, m_mode, m_done, m_rr, pk;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_in[i]  = '0;
        m_out[i] = BASE + STEP * DW'(i);
      end
      m_valid = '0; m_pend = '0; m_ack = '0; m_pub = '0;
      m_act = 0; m_rr = N - 1; m_ch = 0; m_mode = 0; m_done = 0;
    end else begin
      acc   = en_in & ~m_pend;
      start = 0;
      pk    = 0;
      if (!m_act && m_pend != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (!start && m_pend[(m_rr + k) % N]) begin
            start = 1;
            pk = (m_rr + k) % N;
          end
        end
      end
      m_pub = '0;
      if (m_act && m_done == cyc) begin
        if (m_mode == 1)      m_out[m_ch] = m_out[m_ch] + m_in[m_ch];
        else if (m_mode == 2) m_out[m_ch] = ~m_in[m_ch];
        else                  m_out[m_ch] = m_in[m_ch];
        m_valid[m_ch] = 1'b1;
        m_pend[m_ch]  = 1'b0;
        m_pub[m_ch]   = 1'b1;
        m_rr  = m_ch;
        m_act = 0;
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) m_in[i] = data[(N-i)*DW-1 -: DW];
      m_pend = m_pend | acc;
      m_ack  = acc;
      if (start) begin
        m_act  = 1;
        m_ch   = pk;
        m_mode = int'(mode);
        m_done = cyc + L;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ack", en_out, m_ack);
      chk("pub", ipen, m_pub);
      for (int i = 0; i < N; i++) chk("field", field(i), {m_out[i], m_valid[i]});
      chk("busy", busy, (m_pend != '0) || m_act);
    end
  end

  initial begin
    logic [N-1:0] exp_pub;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_f0", field(0), {32'h2468, 1'b0});
    chk("rst_f1", field(1), {32'h369C, 1'b0});
    chk("rst_f2", field(2), {32'h48D0, 1'b0});
    chk("rst_ack", en_out, 0);
    chk("rst_pub", ipen, 0);
    chk("rst_busy", busy, 0);

    // Accumulate on all three channels at once.
    tick();
    en_in = 3'b111; mode = 2'b01;
    set_data(0, 32'd1); set_data(1, 32'd2); set_data(2, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin chk("acc_ack", en_out, 3'b111); en_in = '0; end
      exp_pub = (k == 4) ? 3'b001 : (k == 7) ? 3'b010 : (k == 10) ? 3'b100 : 3'b000;
      chk("acc_pub", ipen, exp_pub);
      if (k == 4)  chk("acc_f0", field(0), {32'h2469, 1'b1});
      if (k == 7)  chk("acc_f1", field(1), {32'h369E, 1'b1});
      if (k == 10) chk("acc_f2", field(2), {32'h48D3, 1'b1});
    end

    // Single pass-through on channel 0.
    tick();
    en_in = 3'b001; mode = 2'b00; set_data(0, 32'hDEADBEEF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin chk("pass_ack", en_out, 3'b001); en_in = '0; end
      if (k == 4) begin
        chk("pass_pub", ipen, 3'b001);
        chk("pass_f0", field(0), {32'hDEADBEEF, 1'b1});
        chk("pass_busy", busy, 0);
      end
    end

    // Invert on channel 1, then re-strobe while pending and across completion.
    tick();
    en_in = 3'b010; mode = 2'b10; set_data(1, 32'h0000FFFF);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin chk("inv_ack", en_out, 3'b010); en_in = '0; end
      if (k == 2) begin en_in = 3'b010; set_data(1, 32'h5); end
      if (k == 3) chk("rej_ack", en_out, 3'b000);
      if (k == 4) begin
        chk("rej_ack_done", en_out, 3'b000);
        chk("inv_pub", ipen, 3'b010);
        chk("inv_f1", field(1), {32'hFFFF0000, 1'b1});
        mode = 2'b00;
      end
      if (k == 5) begin chk("retry_ack", en_out, 3'b010); en_in = '0; end
      if (k == 8) begin
        chk("retry_pub", ipen, 3'b010);
        chk("retry_f1", field(1), {32'h5, 1'b1});
      end
    end

    // Fairness: ch0 re-strobed behind pending ch1, ch2.
    tick();
    en_in = 3'b001; set_data(0, 32'h11);
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) en_in = '0;
      if (k == 2) begin en_in = 3'b110; set_data(1, 32'h22); set_data(2, 32'h33); end
      if (k == 3) begin chk("fair_ack12", en_out, 3'b110); en_in = '0; end
      if (k == 4) begin en_in = 3'b001; set_data(0, 32'h44); end
      if (k == 5) begin chk("fair_ack0", en_out, 3'b001); en_in = '0; end
      exp_pub = (k == 4 || k == 13) ? 3'b001 : (k == 7) ? 3'b010 : (k == 10) ? 3'b100 : 3'b000;
      chk("fair_pub", ipen, exp_pub);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      tick();
      en_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
    end
    tick();
    en_in = '0;
    for (int k = 0; k < 60 && busy; k++) tick();
    chk("drain_busy", busy, 0);

    // Asynchronous reset in the middle of an EXEC.
    tick();
    en_in = 3'b100; mode = 2'b00; set_data(2, 32'hABCD);
    tick();
    en_in = '0;
    tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pub", ipen, 0);
    chk("arst_ack", en_out, 0);
    chk("arst_busy", busy, 0);
    for (int i = 0; i < N; i++) chk("arst_field", field(i), {BASE + STEP * DW'(i), 1'b0});
    repeat (2) tick();
    #3 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_pub", ipen, 0);
    end
    chk("post_rst_f2", field(2), {32'h48D0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
